// File: rtl/bcd_converter_pkg.sv
// Shared definitions for the binary-to-BCD sequencer: state encoding,
// digit geometry and the elaboration-time range check.
package bcd_converter_pkg;

  localparam int unsigned BCD_DIGIT_WIDTH = 4;
  localparam int unsigned RADIX           = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // True when DIGITS decimal digits can hold every N-bit unsigned value.
  function automatic bit digits_cover(input int unsigned n, input int unsigned d);
    logic [127:0] p10;
    logic [127:0] max_val;
    p10 = 128'd1;
    for (int unsigned i = 0; i < d; i++) begin
      p10 = p10 * 128'd10;
    end
    max_val = (128'd1 << n) - 128'd1;
    return p10 > max_val;
  endfunction

endpackage

// File: rtl/bcd_converter.sv
// Binary-to-packed-BCD converter that drives an external divider with
// repeated division by 10; each remainder becomes one decimal digit.
//
// Ports:
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_start, i_value        conversion request and N-bit unsigned value
//   o_busy                  conversion in progress (ISSUE/WAIT)
//   o_finished              level, result valid (DONE)
//   o_bcd, o_digits         packed BCD result (units in [3:0]), digit count
//   o_div_start             one-cycle start pulse to the divider
//   o_div_dividend          current working value
//   o_div_divisor           constant 10
//   i_div_finished          divider result valid
//   i_div_quotient          divider quotient
//   i_div_remainder         divider remainder (< 10)
module bcd_converter
  import bcd_converter_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic                                i_start,
  input  logic [N-1:0]                        i_value,
  output logic                                o_busy,
  output logic                                o_finished,
  output logic [BCD_DIGIT_WIDTH*DIGITS-1:0]   o_bcd,
  output logic [$clog2(DIGITS+1)-1:0]         o_digits,
  output logic                                o_div_start,
  output logic [N-1:0]                        o_div_dividend,
  output logic [N-1:0]                        o_div_divisor,
  input  logic                                i_div_finished,
  input  logic [N-1:0]                        i_div_quotient,
  input  logic [N-1:0]                        i_div_remainder
);

  localparam int unsigned BCD_W = BCD_DIGIT_WIDTH * DIGITS;
  localparam int unsigned KW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DW    = $clog2(DIGITS + 1);

  // Reject parameter sets whose digit count could overflow.
  if (N < 4 || !digits_cover(N, DIGITS)) begin : g_bad_params
    $error("bcd_converter: DIGITS too small for N, or N < 4");
  end

  state_e             r_state;
  logic               r_busy;
  logic               r_finished;
  logic               r_div_start;
  logic [N-1:0]       r_work;
  logic [BCD_W-1:0]   r_bcd;
  logic [DW-1:0]      r_digits;
  logic [KW-1:0]      r_k;

  state_e             w_state;
  logic               w_busy;
  logic               w_finished;
  logic               w_div_start;
  logic [N-1:0]       w_work;
  logic [BCD_W-1:0]   w_bcd;
  logic [DW-1:0]      w_digits;
  logic [KW-1:0]      w_k;

  // Only the low nibble of the remainder carries a digit.
  logic w_unused_rem;
  assign w_unused_rem = ^i_div_remainder;

  // Next-state and next-register values.
  always_comb begin
    w_state     = r_state;
    w_work      = r_work;
    w_bcd       = r_bcd;
    w_digits    = r_digits;
    w_k         = r_k;
    w_busy      = 1'b0;
    w_finished  = 1'b0;
    w_div_start = 1'b0;

    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_work  = i_value;
          w_bcd   = '0;
          w_k     = '0;
          w_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_div_finished) begin
          for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_k == KW'(i)) begin
              w_bcd[i*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH] =
                i_div_remainder[BCD_DIGIT_WIDTH-1:0];
            end
          end
          w_work = i_div_quotient;
          if (i_div_quotient == '0) begin
            w_digits = DW'(r_k) + DW'(1);
            w_state  = ST_DONE;
          end else begin
            w_k     = r_k + KW'(1);
            w_state = ST_ISSUE;
          end
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase

    // Status outputs are registered versions of the upcoming state.
    w_div_start = (w_state == ST_ISSUE);
    w_busy      = (w_state == ST_ISSUE) || (w_state == ST_WAIT);
    w_finished  = (w_state == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_finished  <= 1'b0;
      r_div_start <= 1'b0;
      r_work      <= '0;
      r_bcd       <= '0;
      r_digits    <= '0;
      r_k         <= '0;
    end else begin
      r_state     <= w_state;
      r_busy      <= w_busy;
      r_finished  <= w_finished;
      r_div_start <= w_div_start;
      r_work      <= w_work;
      r_bcd       <= w_bcd;
      r_digits    <= w_digits;
      r_k         <= w_k;
    end
  end

  assign o_busy         = r_busy;
  assign o_finished     = r_finished;
  assign o_bcd          = r_bcd;
  assign o_digits       = r_digits;
  assign o_div_start    = r_div_start;
  assign o_div_dividend = r_work;
  assign o_div_divisor  = N'(RADIX);

endmodule
